isqrt_seq: RTL and testbench
============================

Name: isqrt_seq

Overview:
Parametrised sequential integer square root. It is the successor to the single-width, multiplier-based square-root block.
- Uses a shift/subtract digit recurrence, so no multiplier is needed.
- Radicand width and digits-per-cycle are configurable.
- Provides a start/ready/done handshake and back-to-back operation.
- Sits as a multi-cycle functional unit behind the execute stage; the issuing logic waits on done.

Parameters:
IN_W, 64, radicand width; must be even and >= 4.
BITS_PER_CYCLE, 1, root bits resolved per clock; must be 1 or 2 and must divide IN_W/2.
OUT_W, IN_W/2, root width; derived, not to be overridden.
ITER, OUT_W/BITS_PER_CYCLE, number of CALC cycles; derived.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  request; accepted on a rising edge when start && ready.
value  input  IN_W  radicand; sampled only on the accepting edge.
ready  output  1  high when state is IDLE or DONE.
busy  output  1  high when state is CALC.
done  output  1  high in DONE; result is valid and stable.
result  output  OUT_W  floor(sqrt(value)).
remainder  output  OUT_W+1  value - result^2; present only with ISQRT_REM_EN.

Behaviour:
- Interface: reset is asynchronous, active-high; clock is clock.
- Reset (async, any state): state=IDLE, result=0, remainder=0, done=0, busy=0, ready=1. Internal radicand, partial remainder and counter are cleared.
- States: IDLE, CALC, DONE.
- IDLE -> CALC on start. On that edge:
  - latch value into shift register rad;
  - rem=0, root=0;
  - cnt=ITER-1.
- CALC, each edge, BITS_PER_CYCLE steps chained combinationally. One step is:
  - t = {rem, rad[IN_W-1:IN_W-2]} - {root, 2'b01}, evaluated at OUT_W+2 bits;
  - if t >= 0 (MSB clear): rem=t, root={root,1};
  - else: rem={rem, rad top 2 bits}, root={root,0};
  - rad shifts left by 2.
- CALC -> DONE when cnt==0 after the step; otherwise cnt decrements.
- On entry to DONE, result and remainder are registered from root and rem.
- Latency: start accepted at edge E0 puts done high after edge E0+ITER. Default config gives 32 cycles; BITS_PER_CYCLE=2 gives 16.
- DONE: done, result and remainder held indefinitely until the next accepted start.
  - start in DONE goes directly to CALC, with no IDLE cycle.
  - done drops after that accepting edge, and result keeps its old value until the new completion.
- start while busy: ignored; value is not sampled and no error is flagged.
- start held high continuously: every completion is followed by an immediate restart; done is high for exactly one cycle each time.
- value changing during CALC has no effect.
- Boundaries: value=0 gives result 0. value=2^IN_W-1 gives result 2^OUT_W-1. The remainder never exceeds 2*result, so it fits in OUT_W+1 bits.
- Reset mid-CALC abandons the operation; no done pulse is produced.
- No combinational path from start or value to any output.

Optional Feature:
Macro ISQRT_REM_EN.
- Defined: the remainder port exists and is registered as above.
- Undefined: the port is omitted and the rem storage is narrowed to what the comparison needs. result and timing are identical in both builds.

Decomposition:
- Package isqrt_pkg holds:
  - typedef enum logic [1:0] isqrt_state_e {IDLE, CALC, DONE};
  - function root_w(in_w) returning in_w/2;
  - constant STEP_W offset of 2.
- One sub-module, isqrt_step: combinational single-digit recurrence with inputs rem, root and a 2-bit pair, and outputs rem_next and root_next. It is instantiated BITS_PER_CYCLE times with a generate loop.
- The FSM, counter and registers live in the top.

Test Plan:
- value=0, IN_W=64 -> done after 32 cycles; result=0, remainder=0.
- value=64'hFFFF_FFFF_FFFF_FFFF -> result=32'hFFFF_FFFF, remainder=33'h1_FFFF_FFFE.
- value=99 then, in DONE, start with value=1000000 -> first result=9, remainder=18; done low one cycle; then result=1000, remainder=0, done exactly 32 cycles after the second accept.
- Reset asserted asynchronously mid-edge at cycle 10 of CALC -> outputs zero immediately, ready=1, no done; a new start with value=144 gives 12.
- start pulsed during CALC with value=4 -> ignored; the original operation (value=50) completes with 7, remainder 1.
- BITS_PER_CYCLE=2, IN_W=16, value=16'hFFFF -> done after 4 cycles, result=8'hFF, remainder=9'h1FE. Also run a random sweep of 10k values checked against a reference model.

Source files
------------

// File: rtl/isqrt_pkg.sv
// Shared types and helpers for the sequential integer square root unit.
package isqrt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } isqrt_state_e;

    // Each recurrence step consumes one pair of radicand bits.
    localparam int STEP_W = 2;

    // The root of an in_w-bit radicand needs half as many bits.
    function automatic int root_w(input int in_w);
        return in_w / 2;
    endfunction

endpackage

// File: rtl/isqrt_step.sv
// One digit of the shift/subtract square-root recurrence (purely combinational).
// The incoming partial remainder is bounded by 2*root, so it fits in OUT_W bits
// before the last step; the produced remainder needs one more bit.
module isqrt_step
    import isqrt_pkg::*;
#(
    parameter int OUT_W = 32
) (
    input  logic [OUT_W-1:0]  rem,
    input  logic [OUT_W-1:0]  root,
    input  logic [STEP_W-1:0] pair,
    output logic [OUT_W:0]    rem_next,
    output logic [OUT_W-1:0]  root_next
);

    logic        [OUT_W+1:0] shifted;
    logic signed [OUT_W+1:0] trial;
    logic                    neg;

    // Trial subtraction of {root,01} from the remainder extended by the next bit pair.
    always_comb begin
        shifted   = {rem, pair};
        trial     = signed'(shifted) - signed'({root, 2'b01});
        neg       = trial[OUT_W+1];
        rem_next  = neg ? shifted[OUT_W:0] : trial[OUT_W:0];
        root_next = {root[OUT_W-2:0], ~neg};
    end

endmodule

// File: rtl/isqrt_seq.sv
// Sequential integer square root: floor(sqrt(value)) by digit recurrence,
// BITS_PER_CYCLE root bits per clock, start/ready/done handshake.
// Optional macro ISQRT_REM_EN adds the registered remainder output.
module isqrt_seq
    import isqrt_pkg::*;
#(
    parameter int IN_W           = 64,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic [IN_W-1:0]               value,
    output logic                          ready,
    output logic                          busy,
    output logic                          done,
    output logic [root_w(IN_W)-1:0]       result
`ifdef ISQRT_REM_EN
    ,
    output logic [root_w(IN_W):0]         remainder
`endif
);

    localparam int OUT_W = root_w(IN_W);
    localparam int ITER  = OUT_W / BITS_PER_CYCLE;
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

    if ((IN_W % 2) != 0 || IN_W < 4 || (BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 2)
        || (OUT_W % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
        $error("isqrt_seq: unsupported IN_W / BITS_PER_CYCLE combination");
    end

    isqrt_state_e     state;
    logic [IN_W-1:0]  rad;
    logic [OUT_W-1:0] rem;
    logic [OUT_W-1:0] root;
    logic [CNT_W-1:0] cnt;

    // Combinational chain of recurrence steps evaluated once per CALC cycle.
    logic [OUT_W-1:0] rem_in  [BITS_PER_CYCLE+1];
    logic [OUT_W-1:0] root_c  [BITS_PER_CYCLE+1];
    logic [OUT_W:0]   rem_out [BITS_PER_CYCLE];

    assign rem_in[0] = rem;
    assign root_c[0] = root;

    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
        isqrt_step #(.OUT_W(OUT_W)) u_step (
            .rem       (rem_in[i]),
            .root      (root_c[i]),
            .pair      (rad[IN_W-1-STEP_W*i -: STEP_W]),
            .rem_next  (rem_out[i]),
            .root_next (root_c[i+1])
        );
        // Intermediate remainders stay below 2^OUT_W, so the top bit can be dropped.
        assign rem_in[i+1] = rem_out[i][OUT_W-1:0];
    end

    // Control FSM, datapath registers and registered handshake outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rad       <= '0;
            rem       <= '0;
            root      <= '0;
            cnt       <= '0;
            result    <= '0;
`ifdef ISQRT_REM_EN
            remainder <= '0;
`endif
            done      <= 1'b0;
            busy      <= 1'b0;
            ready     <= 1'b1;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= CALC;
                        rad   <= value;
                        rem   <= '0;
                        root  <= '0;
                        cnt   <= CNT_W'(ITER - 1);
                        done  <= 1'b0;
                        busy  <= 1'b1;
                        ready <= 1'b0;
                    end
                end
                CALC: begin
                    rad  <= rad << (STEP_W * BITS_PER_CYCLE);
                    rem  <= rem_in[BITS_PER_CYCLE];
                    root <= root_c[BITS_PER_CYCLE];
                    if (cnt == '0) begin
                        state     <= DONE;
                        result    <= root_c[BITS_PER_CYCLE];
`ifdef ISQRT_REM_EN
                        remainder <= rem_out[BITS_PER_CYCLE-1];
`endif
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        ready     <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_isqrt_seq.sv
// Bench for isqrt_seq: a 64-bit/1-bit-per-cycle instance and a
// 16-bit/2-bits-per-cycle instance, checked against a binary-search root model.
module tb_isqrt_seq;

    localparam int ITER1 = 32;
    localparam int ITER2 = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic        start1 = 1'b0;
    logic [63:0] value1 = '0;
    logic        ready1, busy1, done1;
    logic [31:0] result1;

    logic        start2 = 1'b0;
    logic [15:0] value2 = '0;
    logic        ready2, busy2, done2;
    logic [7:0]  result2;

`ifdef ISQRT_REM_EN
    logic [32:0] remainder1;
    logic [8:0]  remainder2;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    isqrt_seq #(.IN_W(64), .BITS_PER_CYCLE(1)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start1),
        .value     (value1),
        .ready     (ready1),
        .busy      (busy1),
        .done      (done1),
        .result    (result1)
`ifdef ISQRT_REM_EN
        ,
        .remainder (remainder1)
`endif
    );

    isqrt_seq #(.IN_W(16), .BITS_PER_CYCLE(2)) dut2 (
        .clock     (clock),
        .reset     (reset),
        .start     (start2),
        .value     (value2),
        .ready     (ready2),
        .busy      (busy2),
        .done      (done2),
        .result    (result2)
`ifdef ISQRT_REM_EN
        ,
        .remainder (remainder2)
`endif
    );

    // Reference: largest r with r*r <= v, found by binary search.
    function automatic logic [31:0] ref_root(input logic [63:0] v);
        logic [63:0] lo, hi, mid;
        lo = 64'd0;
        hi = 64'h0000_0000_FFFF_FFFF;
        while (lo < hi) begin
            mid = (lo + hi + 64'd1) >> 1;
            if (mid * mid <= v) lo = mid;
            else                hi = mid - 64'd1;
        end
        return lo[31:0];
    endfunction

    function automatic logic [32:0] ref_rem(input logic [63:0] v);
        logic [63:0] r, d;
        r = {32'd0, ref_root(v)};
        d = v - r * r;
        return d[32:0];
    endfunction

    // Issue one operation on the 64-bit instance and wait (bounded) for done.
    task automatic op64(input logic [63:0] v, output int cyc,
                        output logic d_after, output logic [31:0] r_after);
        @(negedge clock);
        start1 = 1'b1;
        value1 = v;
        @(negedge clock);
        start1 = 1'b0;
        value1 = {$urandom, $urandom};
        d_after = done1;
        r_after = result1;
        cyc = 0;
        while (done1 !== 1'b1 && cyc < 4 * ITER1) begin
            @(negedge clock);
            cyc++;
        end
    endtask

    task automatic op16(input logic [15:0] v, output int cyc);
        @(negedge clock);
        start2 = 1'b1;
        value2 = v;
        @(negedge clock);
        start2 = 1'b0;
        value2 = 16'($urandom);
        cyc = 0;
        while (done2 !== 1'b1 && cyc < 4 * ITER2) begin
            @(negedge clock);
            cyc++;
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        total++; if (ready1 !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ready1); end
        total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy1); end
        total++; if (done1 !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done1); end
        total++; if (result1 !== 32'd0) begin bad++; $display("FAIL reset_result got=%0h want=0", result1); end
        total++; if (ready2 !== 1'b1 || done2 !== 1'b0) begin bad++; $display("FAIL reset_dut2 ready=%b done=%b want=1/0", ready2, done2); end
`ifdef ISQRT_REM_EN
        total++; if (remainder1 !== 33'd0) begin bad++; $display("FAIL reset_rem got=%0h want=0", remainder1); end
`endif
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_fixed();
        logic [63:0] vals [2];
        int cyc;
        logic d_a;
        logic [31:0] r_a;
        vals[0] = 64'd0;
        vals[1] = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int k = 0; k < 2; k++) begin
            op64(vals[k], cyc, d_a, r_a);
            total++; if (cyc !== ITER1) begin bad++; $display("FAIL fixed_latency v=%0h got=%0d want=%0d", vals[k], cyc, ITER1); end
            total++; if (busy1 !== 1'b0 || ready1 !== 1'b1) begin bad++; $display("FAIL fixed_flags busy=%b ready=%b want=0/1", busy1, ready1); end
            total++; if (result1 !== ref_root(vals[k])) begin bad++; $display("FAIL fixed_result v=%0h got=%0h want=%0h", vals[k], result1, ref_root(vals[k])); end
`ifdef ISQRT_REM_EN
            total++; if (remainder1 !== ref_rem(vals[k])) begin bad++; $display("FAIL fixed_rem v=%0h got=%0h want=%0h", vals[k], remainder1, ref_rem(vals[k])); end
`endif
        end
        total++; if (result1 !== 32'hFFFF_FFFF) begin bad++; $display("FAIL max_result got=%0h want=ffffffff", result1); end
`ifdef ISQRT_REM_EN
        total++; if (remainder1 !== 33'h1_FFFF_FFFE) begin bad++; $display("FAIL max_rem got=%0h want=1fffffffe", remainder1); end
`endif
    endtask

    task automatic test_restart_from_done();
        int cyc;
        logic d_a;
        logic [31:0] r_a;
        op64(64'd99, cyc, d_a, r_a);
        total++; if (result1 !== 32'd9) begin bad++; $display("FAIL r99_result got=%0d want=9", result1); end
`ifdef ISQRT_REM_EN
        total++; if (remainder1 !== 33'd18) begin bad++; $display("FAIL r99_rem got=%0d want=18", remainder1); end
`endif
        // Several idle cycles in DONE: output must hold.
        repeat (3) @(negedge clock);
        total++; if (done1 !== 1'b1 || result1 !== 32'd9) begin bad++; $display("FAIL done_hold done=%b result=%0d want=1/9", done1, result1); end
        op64(64'd1000000, cyc, d_a, r_a);
        total++; if (d_a !== 1'b0) begin bad++; $display("FAIL restart_done_drop got=%b want=0", d_a); end
        total++; if (r_a !== 32'd9) begin bad++; $display("FAIL restart_result_held got=%0d want=9", r_a); end
        total++; if (cyc !== ITER1) begin bad++; $display("FAIL restart_latency got=%0d want=%0d", cyc, ITER1); end
        total++; if (result1 !== 32'd1000) begin bad++; $display("FAIL r1e6_result got=%0d want=1000", result1); end
`ifdef ISQRT_REM_EN
        total++; if (remainder1 !== 33'd0) begin bad++; $display("FAIL r1e6_rem got=%0d want=0", remainder1); end
`endif
    endtask

    task automatic test_reset_mid_calc();
        int cyc;
        int seen;
        logic d_a;
        logic [31:0] r_a;
        @(negedge clock);
        start1 = 1'b1;
        value1 = 64'd123456789;
        @(negedge clock);
        start1 = 1'b0;
        repeat (9) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        total++; if (ready1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0) begin bad++; $display("FAIL midrst_flags ready=%b busy=%b done=%b want=1/0/0", ready1, busy1, done1); end
        total++; if (result1 !== 32'd0) begin bad++; $display("FAIL midrst_result got=%0d want=0", result1); end
        @(negedge clock);
        reset = 1'b0;
        seen = 0;
        for (int k = 0; k < ITER1 + 4; k++) begin
            @(negedge clock);
            if (done1 === 1'b1) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL midrst_no_done got=%0d pulses want=0", seen); end
        op64(64'd144, cyc, d_a, r_a);
        total++; if (cyc !== ITER1 || result1 !== 32'd12) begin bad++; $display("FAIL after_rst cyc=%0d result=%0d want=%0d/12", cyc, result1, ITER1); end
    endtask

    task automatic test_start_while_busy();
        int cyc;
        @(negedge clock);
        start1 = 1'b1;
        value1 = 64'd50;
        @(negedge clock);
        start1 = 1'b0;
        cyc = 0;
        repeat (5) begin @(negedge clock); cyc++; end
        start1 = 1'b1;
        value1 = 64'd4;
        @(negedge clock);
        cyc++;
        start1 = 1'b0;
        value1 = 64'hDEAD_BEEF_0000_1234;
        while (done1 !== 1'b1 && cyc < 4 * ITER1) begin
            @(negedge clock);
            cyc++;
        end
        total++; if (cyc !== ITER1) begin bad++; $display("FAIL busy_latency got=%0d want=%0d", cyc, ITER1); end
        total++; if (result1 !== 32'd7) begin bad++; $display("FAIL busy_result got=%0d want=7", result1); end
`ifdef ISQRT_REM_EN
        total++; if (remainder1 !== 33'd1) begin bad++; $display("FAIL busy_rem got=%0d want=1", remainder1); end
`endif
    endtask

    task automatic test_back_to_back();
        logic [63:0] cur;
        int cyc;
        cur = {$urandom, $urandom};
        @(negedge clock);
        start1 = 1'b1;
        value1 = cur;
        for (int k = 0; k < 3; k++) begin
            cyc = 0;
            do begin
                @(negedge clock);
                cyc++;
                if (cyc == 1) begin
                    total++; if (done1 !== 1'b0) begin bad++; $display("FAIL b2b_done_width k=%0d got=%b want=0", k, done1); end
                end
            end while (done1 !== 1'b1 && cyc < 4 * ITER1);
            total++; if (cyc !== ITER1 + 1) begin bad++; $display("FAIL b2b_period k=%0d got=%0d want=%0d", k, cyc, ITER1 + 1); end
            total++; if (result1 !== ref_root(cur)) begin bad++; $display("FAIL b2b_result v=%0h got=%0h want=%0h", cur, result1, ref_root(cur)); end
`ifdef ISQRT_REM_EN
            total++; if (remainder1 !== ref_rem(cur)) begin bad++; $display("FAIL b2b_rem v=%0h got=%0h want=%0h", cur, remainder1, ref_rem(cur)); end
`endif
            cur = {$urandom, $urandom};
            value1 = cur;
        end
        start1 = 1'b0;
    endtask

    task automatic test_random64();
        logic [63:0] v;
        int cyc;
        logic d_a;
        logic [31:0] r_a;
        for (int k = 0; k < 30; k++) begin
            v = {$urandom, $urandom} >> $urandom_range(0, 63);
            op64(v, cyc, d_a, r_a);
            total++; if (cyc !== ITER1 || result1 !== ref_root(v)) begin bad++; $display("FAIL rand64 v=%0h cyc=%0d got=%0h want=%0h", v, cyc, result1, ref_root(v)); end
`ifdef ISQRT_REM_EN
            total++; if (remainder1 !== ref_rem(v)) begin bad++; $display("FAIL rand64_rem v=%0h got=%0h want=%0h", v, remainder1, ref_rem(v)); end
`endif
        end
    endtask

    task automatic test_radix4_sweep();
        logic [15:0] v;
        logic [31:0] want;
        logic [32:0] want_rem;
        int cyc;
        op16(16'hFFFF, cyc);
        total++; if (cyc !== ITER2) begin bad++; $display("FAIL r4_latency got=%0d want=%0d", cyc, ITER2); end
        total++; if (result2 !== 8'hFF) begin bad++; $display("FAIL r4_max_result got=%0h want=ff", result2); end
`ifdef ISQRT_REM_EN
        total++; if (remainder2 !== 9'h1FE) begin bad++; $display("FAIL r4_max_rem got=%0h want=1fe", remainder2); end
`endif
        for (int k = 0; k < 10000; k++) begin
            v = 16'($urandom_range(0, 65535));
            op16(v, cyc);
            want = ref_root({48'd0, v});
            want_rem = ref_rem({48'd0, v});
            total++; if (cyc !== ITER2 || result2 !== want[7:0]) begin bad++; $display("FAIL r4_sweep v=%0h cyc=%0d got=%0h want=%0h", v, cyc, result2, want[7:0]); end
`ifdef ISQRT_REM_EN
            total++; if (remainder2 !== want_rem[8:0]) begin bad++; $display("FAIL r4_sweep_rem v=%0h got=%0h want=%0h", v, remainder2, want_rem[8:0]); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_restart_from_done();
        test_reset_mid_calc();
        test_start_while_busy();
        test_back_to_back();
        test_random64();
        test_radix4_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
